// File: rtl/updown_mod_counter_if.sv
// Handshake/control bundle for updown_mod_counter: run controls and limit
// selection in, registered count/status/BCD out.
interface updown_mod_counter_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_down;
  logic                  one_shot;
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [1:0]            mod_select;
  logic [WIDTH-1:0]      max_value;
  logic [WIDTH-1:0]      count;
  logic                  wrap;
  logic                  done;
  logic                  running;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output en, up_down, one_shot, start, stop, clear, load,
           load_value, mod_select, max_value,
    input  count, wrap, done, running, bcd
  );

  modport slave (
    input  en, up_down, one_shot, start, stop, clear, load,
           load_value, mod_select, max_value,
    output count, wrap, done, running, bcd
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with IDLE/RUN/DONE run control, one-shot halt and
// optional registered BCD output (enabled by UPDOWN_MOD_COUNTER_BCD_EN).
module updown_mod_counter #(
  parameter int WIDTH  = 14,
  parameter int LIMIT1 = 99,
  parameter int LIMIT2 = 999,
  parameter int LIMIT3 = 1999,
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  updown_mod_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [WIDTH-1:0] limit;
  logic             step;
  logic             hit;

  function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] v,
                                                      input logic [WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    case (bus.mod_select)
      2'b00:   limit = bus.max_value;
      2'b01:   limit = WIDTH'(LIMIT1);
      2'b10:   limit = WIDTH'(LIMIT2);
      default: limit = WIDTH'(LIMIT3);
    endcase
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    hit     = 1'b0;
    state_d = state_q;
    // stop freezes the count in the same cycle it leaves RUN
    step    = (state_q == S_RUN) && bus.en && !bus.stop;

    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = clamp_to_limit(bus.load_value, limit);
    end else if (step) begin
      if (bus.up_down) begin
        if (count_q >= limit) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
          if (bus.one_shot && count_d == limit) begin
            wrap_d = 1'b1;
            hit    = 1'b1;
          end
        end
      end else begin
        if (count_q == '0) begin
          count_d = limit;
          wrap_d  = 1'b1;
        end else if (count_q > limit) begin
          count_d = limit;
        end else begin
          count_d = count_q - WIDTH'(1);
          if (bus.one_shot && count_d == '0) begin
            wrap_d = 1'b1;
            hit    = 1'b1;
          end
        end
      end
    end

    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (bus.stop) state_d = S_IDLE;
               else if (hit) state_d = S_DONE;
      S_DONE:  if (bus.clear || bus.load) state_d = S_IDLE;
               else if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // Stage p0: count, status and FSM registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;

`ifdef UPDOWN_MOD_COUNTER_BCD_EN
  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] bin);
    logic [4*DIGITS-1:0] acc;
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*DIGITS-2:0], bin[i]};
    end
    return acc;
  endfunction

  logic [4*DIGITS-1:0] bcd_d, bcd_q;

  assign bcd_d = to_bcd(count_q);

  // Stage p1: BCD trails the count register by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign bus.bcd = bcd_q;
`else
  assign bus.bcd = {(4*DIGITS){1'b0}};
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed + randomized bench for updown_mod_counter against a behavioural
// model of the counting rules; works in both BCD and non-BCD builds.
module tb_updown_mod_counter;
  localparam int WIDTH  = 14;
  localparam int LIM1   = 99;
  localparam int LIM2   = 999;
  localparam int LIM3   = 1999;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) ifc ();

  updown_mod_counter #(
    .WIDTH(WIDTH), .LIMIT1(LIM1), .LIMIT2(LIM2), .LIMIT3(LIM3), .DIGITS(DIGITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = idle, 1 = running, 2 = finished (one-shot halted)
  int m_mode, m_count, m_bcd;
  bit m_wrap;

  function automatic int cur_limit();
    case (ifc.mod_select)
      2'b00:   return int'(ifc.max_value);
      2'b01:   return LIM1;
      2'b10:   return LIM2;
      default: return LIM3;
    endcase
  endfunction

  function automatic int bcd_of(int v);
    int r = 0;
    int p = 1;
`ifdef UPDOWN_MOD_COUNTER_BCD_EN
    for (int d = 0; d < DIGITS; d++) begin
      r = r | (((v / p) % 10) << (4 * d));
      p = p * 10;
    end
`else
    r = v * 0 + p * 0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_bcd = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    int lim   = cur_limit();
    int nxt   = m_count;
    bit w     = 0;
    bit halt  = 0;
    m_bcd = bcd_of(m_count);
    if (ifc.clear) nxt = 0;
    else if (ifc.load) nxt = (int'(ifc.load_value) > lim) ? lim : int'(ifc.load_value);
    else if (m_mode == 1 && ifc.en && !ifc.stop) begin
      if (ifc.up_down) begin
        if (m_count >= lim) begin nxt = 0; w = 1; end
        else begin
          nxt = m_count + 1;
          if (ifc.one_shot && nxt == lim) begin w = 1; halt = 1; end
        end
      end else begin
        if (m_count == 0) begin nxt = lim; w = 1; end
        else if (m_count > lim) nxt = lim;
        else begin
          nxt = m_count - 1;
          if (ifc.one_shot && nxt == 0) begin w = 1; halt = 1; end
        end
      end
    end
    case (m_mode)
      0: if (ifc.start) m_mode = 1;
      1: if (ifc.stop) m_mode = 0; else if (halt) m_mode = 2;
      default: if (ifc.clear || ifc.load) m_mode = 0; else if (ifc.start) m_mode = 1;
    endcase
    m_count = nxt;
    m_wrap  = w;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".count"},   32'(ifc.count),   m_count);
    check({tag, ".wrap"},    32'(ifc.wrap),    32'(m_wrap));
    check({tag, ".done"},    32'(ifc.done),    32'(m_mode == 2));
    check({tag, ".running"}, 32'(ifc.running), 32'(m_mode == 1));
    check({tag, ".bcd"},     32'(ifc.bcd),     m_bcd);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    int wraps;
    int frozen;
    reset = 1'b1;
    ifc.en = 0; ifc.up_down = 1; ifc.one_shot = 0; ifc.start = 0; ifc.stop = 0;
    ifc.clear = 0; ifc.load = 0; ifc.load_value = '0; ifc.mod_select = 2'b01;
    ifc.max_value = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset = 1'b0;

    // Up count through 0..99 and wrap
    ifc.en = 1; ifc.start = 1;
    tick("t1_start");
    ifc.start = 0;
    for (int i = 0; i < 99; i++) tick("t1_up");
    check("t1_top", 32'(ifc.count), 99);
    tick("t1_wrap");
    check("t1_wrap_pulse", 32'(ifc.wrap), 1);
    check("t1_wrap_zero", 32'(ifc.count), 0);
    tick("t1_after");
    check("t1_wrap_low", 32'(ifc.wrap), 0);
    check("t1_running", 32'(ifc.running), 1);

    // One-shot down from 5 with LIMIT2
    ifc.up_down = 0; ifc.mod_select = 2'b10; ifc.one_shot = 1;
    ifc.load = 1; ifc.load_value = 14'd5;
    tick("t2_load");
    ifc.load = 0;
    wraps = 0;
    for (int i = 0; i < 5; i++) begin
      tick("t2_down");
      check("t2_seq", 32'(ifc.count), 32'(4 - i));
      wraps += int'(ifc.wrap);
    end
    check("t2_one_wrap", 32'(wraps), 1);
    check("t2_done", 32'(ifc.done), 1);
    for (int i = 0; i < 10; i++) tick("t2_hold");
    check("t2_hold_zero", 32'(ifc.count), 0);

    // Runtime limit, clamped load, limit shrink below count
    ifc.one_shot = 0; ifc.mod_select = 2'b00; ifc.max_value = 14'd50;
    ifc.load = 1; ifc.load_value = 14'd80;
    tick("t3_load");
    check("t3_clamp", 32'(ifc.count), 50);
    check("t3_idle", 32'(ifc.done), 0);
    ifc.load = 0; ifc.start = 1;
    tick("t3_start");
    ifc.start = 0; ifc.max_value = 14'd20; ifc.up_down = 1;
    tick("t3_shrink_up");
    check("t3_up_zero", 32'(ifc.count), 0);
    check("t3_up_wrap", 32'(ifc.wrap), 1);
    ifc.max_value = 14'd50; ifc.load = 1; ifc.load_value = 14'd45;
    tick("t3_reload");
    ifc.load = 0; ifc.max_value = 14'd20; ifc.up_down = 0;
    tick("t3_shrink_down");
    check("t3_down_lim", 32'(ifc.count), 20);
    check("t3_down_nowrap", 32'(ifc.wrap), 0);

    // Clear beats load; stop beats start
    ifc.clear = 1; ifc.load = 1; ifc.load_value = 14'd10;
    tick("t4_clr_ld");
    check("t4_clr_wins", 32'(ifc.count), 0);
    ifc.clear = 0; ifc.load = 0; ifc.up_down = 1;
    repeat (3) tick("t4_run");
    frozen = m_count;
    ifc.stop = 1; ifc.start = 1;
    tick("t4_stop");
    ifc.stop = 0; ifc.start = 0;
    repeat (5) tick("t4_frozen");
    check("t4_frozen_cnt", 32'(ifc.count), 32'(frozen));
    check("t4_idle", 32'(ifc.running), 0);

    // Asynchronous reset at count 37
    ifc.mod_select = 2'b01; ifc.clear = 1; ifc.start = 1;
    tick("t5_restart");
    ifc.clear = 0; ifc.start = 0;
    repeat (37) tick("t5_up");
    check("t5_at37", 32'(ifc.count), 37);
    reset = 1'b1;
    #1;
    model_reset();
    check("t5_rst_count", 32'(ifc.count), 0);
    check("t5_rst_bcd", 32'(ifc.bcd), 0);
    check_all("t5_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) tick("t5_idle");
    check("t5_still_idle", 32'(ifc.running), 0);

    // BCD of 1234
    ifc.mod_select = 2'b11; ifc.load = 1; ifc.load_value = 14'd1234;
    tick("t6_load");
    ifc.load = 0;
    tick("t6_bcd");
`ifdef UPDOWN_MOD_COUNTER_BCD_EN
    check("t6_bcd_val", 32'(ifc.bcd), 32'h1234);
`else
    check("t6_bcd_val", 32'(ifc.bcd), 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ifc.en         = ($urandom % 4) != 0;
      ifc.up_down    = $urandom % 2;
      ifc.one_shot   = ($urandom % 3) == 0;
      ifc.start      = ($urandom % 8) == 0;
      ifc.stop       = ($urandom % 16) == 0;
      ifc.clear      = ($urandom % 40) == 0;
      ifc.load       = ($urandom % 20) == 0;
      ifc.load_value = 14'($urandom_range(0, 2100));
      if (($urandom % 50) == 0) ifc.mod_select = 2'($urandom % 4);
      if (($urandom % 30) == 0) ifc.max_value = 14'($urandom % 64);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter for the display datapath, driving the 7‑segment digit path in place of the fixed up‑only counter. Adds width/limit parameters, direction control, synchronous load and clear, a count‑enable tick, and a one‑shot mode that halts at the terminal value, all sequenced by a small run‑control state machine. Outputs a registered count, a terminal‑count wrap pulse and a done flag. BCD digit outputs are optional.

## Interface
- `WIDTH`, 14: count and limit width in bits.
- `LIMIT1`, 99: limit used when `mod_select`=01.
- `LIMIT2`, 999: limit used when `mod_select`=10.
- `LIMIT3`, 1999: limit used when `mod_select`=11.
- `DIGITS`, 4: number of BCD digits on `bcd`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active‑high reset.
- `en`  in  1  count‑enable tick; one step per cycle while high.
- `up_down`  in  1  1 = count up, 0 = count down.
- `one_shot`  in  1  1 = halt at terminal, 0 = wrap continuously.
- `start`  in  1  IDLE→RUN, and DONE→RUN.
- `stop`  in  1  RUN→IDLE (count holds).
- `clear`  in  1  sync clear of count to 0.
- `load`  in  1  sync load of `load_value`.
- `load_value`  in  WIDTH  value to load.
- `mod_select`  in  2  limit select: 00 = `max_value`, 01/10/11 = LIMIT1/2/3.
- `max_value`  in  WIDTH  run‑time limit.
- `count`  out  WIDTH  current count.
- `wrap`  out  1  one‑cycle terminal pulse.
- `done`  out  1  high in DONE state.
- `running`  out  1  high in RUN state.
- `bcd`  out  4*DIGITS  BCD of `count`, least‑significant digit in [3:0].

## Operation
- Limit L is selected combinationally by `mod_select`; limit parameters are truncated to WIDTH.
- FSM states:
  - IDLE (reset state): count frozen.
  - RUN: count steps on `en`.
  - DONE: count frozen at the terminal value.
- FSM transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`; `stop` wins over `start`.
  - RUN→DONE when `one_shot`=1 and an enabled step reaches the terminal value.
  - DONE→RUN on `start`: wraps on the first enabled step.
  - DONE→IDLE on `load` or `clear`.
- Terminal value: L when counting up, 0 when counting down.
- Step rules in RUN with `en`=1:
  - Up: count ≥ L → 0 with `wrap`=1; otherwise count+1.
  - Down: count = 0 → L with `wrap`=1; count > L → L without `wrap`; otherwise count−1.
  - One‑shot: the step that reaches the terminal value asserts `wrap` and enters DONE. The count stays at L (up) or 0 (down); it does not wrap.
- Priority per cycle: `reset` > `clear` > `load` > step. `clear` and `load` act in every state.
- Load: count ← min(`load_value`, L). No `wrap` on load.
- Limit changed mid‑run so that count > L:
  - Next up step gives 0 with `wrap`.
  - Next down step gives L.
- L = 0: count stays 0. `wrap` pulses every enabled RUN step (continuous mode).
- `up_down` may change on any cycle and takes effect on the next step.

## Timing
- Reset values: `count`=0, `wrap`=0, `done`=0, `running`=0, `bcd`=0, FSM = IDLE.
- `count`, `wrap`, `done`, `running` are registered and update at the same edge that samples the inputs: 1‑cycle latency.
- `wrap` is high for exactly the one cycle after the terminal step.
- `bcd` has 2‑cycle latency from the sampling edge: it lags `count` by one cycle.
- Reset mid‑run clears everything asynchronously. No pulse is issued on reset release.

## Configuration
- `UPDOWN_MOD_COUNTER_BCD_EN` defined: `bcd` is a registered double‑dabble conversion of `count`. Digits ≥ 10^DIGITS are undefined.
- `UPDOWN_MOD_COUNTER_BCD_EN` undefined: `bcd` is tied to 0 and no conversion logic is built.

## Test plan
- Reset, `start`, `en`=1, up, `mod_select`=01 → count 0…99, then 0 with `wrap` high for one cycle; `running`=1.
- Down, `mod_select`=10, `load` 5, `one_shot`=1 → count 4,3,2,1,0. `wrap` pulses once, `done`=1, count holds at 0 for 10 further cycles.
- `mod_select`=00, `max_value`=50, `load_value`=80 → count=50. Switch to `max_value`=20 at count 50, up step → count 0 with `wrap`.
- `load` and `clear` in the same cycle → count 0. `stop` and `start` in the same cycle in RUN → IDLE, count frozen despite `en`.
- Assert `reset` mid‑count at 37 → `count`, `wrap`, `done`, `bcd` all 0 immediately; after release the counter stays IDLE until `start`.
- BCD build: count=1234 → `bcd`=0x1234 one cycle later. Non‑BCD build → `bcd`=0 throughout.
